// File: rtl/beat_packer_if.sv
// Handshake bundle between an upstream beat source, beat_packer and a downstream word sink.
// BEAT_PACKER_PARITY_EN adds the out_par signal to the bundle.
interface beat_packer_if #(
    parameter int WD    = 4,
    parameter int BEATS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WD-1:0]         in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [WD*BEATS-1:0]   out_data;
    logic [4:0]            out_cnt;
`ifdef BEAT_PACKER_PARITY_EN
    logic                  out_par;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_cnt, out_par
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_cnt, out_par
    );
`else
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_cnt
    );
`endif
endinterface

// File: rtl/beat_packer.sv
// Packs WD-bit beats into BEATS-beat words, with early close on in_last and zero padding.
// Optional feature: BEAT_PACKER_PARITY_EN adds out_par, the XOR reduction of out_data.
module beat_packer #(
    parameter int WD    = 4,
    parameter int BEATS = 3
) (
    input  logic          clk,
    input  logic          rst,
    beat_packer_if.slave  bus
);
    localparam int IW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

    typedef enum logic {FILL, FULL} state_t;

    state_t                state, next_state;
    logic [IW-1:0]         idx;
    logic [WD*BEATS-1:0]   fill_buf;
    logic [WD*BEATS-1:0]   word_next;
    logic [WD*BEATS-1:0]   out_data_q;
    logic [4:0]            out_cnt_q;
    logic                  in_ready_c;
    logic                  out_valid_c;
    logic                  beat_xfer;
    logic                  word_xfer;
    logic                  close_word;
`ifdef BEAT_PACKER_PARITY_EN
    logic                  out_par_q;
`endif

    // The word under construction with the incoming beat dropped into the current slot.
    always_comb begin
        word_next = fill_buf;
        for (int k = 0; k < BEATS; k++) begin
            if (idx == IW'(k)) begin
                word_next[k*WD +: WD] = bus.in_data;
            end
        end
    end

    // While a word is held, an upstream beat may only enter alongside the word leaving.
    always_comb begin
        in_ready_c  = 1'b1;
        out_valid_c = 1'b0;
        next_state  = state;
        unique case (state)
            FILL: begin
                in_ready_c = 1'b1;
            end
            FULL: begin
                out_valid_c = 1'b1;
                in_ready_c  = bus.out_ready;
            end
            default: begin
                in_ready_c = 1'b1;
            end
        endcase
        beat_xfer  = bus.in_valid && in_ready_c;
        word_xfer  = out_valid_c && bus.out_ready;
        close_word = beat_xfer && ((idx == LAST_IDX) || bus.in_last);
        if (close_word) begin
            next_state = FULL;
        end else if (word_xfer) begin
            next_state = FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            idx        <= '0;
            fill_buf   <= '0;
            out_data_q <= '0;
            out_cnt_q  <= '0;
`ifdef BEAT_PACKER_PARITY_EN
            out_par_q  <= 1'b0;
`endif
        end else begin
            state <= next_state;
            // Clearing the fill buffer on close is what guarantees zero padding after in_last.
            if (close_word) begin
                out_data_q <= word_next;
                out_cnt_q  <= 5'(idx) + 5'd1;
                idx        <= '0;
                fill_buf   <= '0;
`ifdef BEAT_PACKER_PARITY_EN
                out_par_q  <= ^word_next;
`endif
            end else if (beat_xfer) begin
                fill_buf <= word_next;
                idx      <= idx + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_cnt   = out_cnt_q;
`ifdef BEAT_PACKER_PARITY_EN
    assign bus.out_par   = out_par_q;
`endif

endmodule
